// File: rtl/settings_pkg.sv
// Shared definitions for the settings command path: command codes, frame sizes
// and the encoder state type.
package settings_pkg;

  localparam logic [7:0] CMD_DUMP_ALL  = 8'd0;
  localparam logic [7:0] CMD_MAX_ROW   = 8'd1;
  localparam logic [7:0] CMD_MAX_COL   = 8'd2;
  localparam logic [7:0] CMD_DATA_MIN  = 8'd3;
  localparam logic [7:0] CMD_DATA_MAX  = 8'd4;
  localparam logic [7:0] CMD_COUNTDOWN = 8'd5;

  localparam int FRAME_BYTES  = 5;
  localparam int NUM_SETTINGS = 5;
  localparam int DUMP_BYTES   = FRAME_BYTES * NUM_SETTINGS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] max_row;
    logic [31:0] max_col;
    logic [31:0] data_min;
    logic [31:0] data_max;
    logic [31:0] countdown_time;
  } settings_t;

endpackage

// File: rtl/settings_byte_select.sv
// Picks one byte of a settings frame: byte 0 is the command code, bytes 1..4
// are the selected 32-bit value in little-endian order.
module settings_byte_select
  import settings_pkg::*;
(
  input  logic [7:0]  cmd_i,
  input  logic [2:0]  byte_idx_i,
  input  logic [31:0] max_row_i,
  input  logic [31:0] max_col_i,
  input  logic [31:0] data_min_i,
  input  logic [31:0] data_max_i,
  input  logic [31:0] countdown_time_i,
  output logic [7:0]  byte_o
);

  logic [31:0] value;

  always_comb begin
    value = '0;
    case (cmd_i)
      CMD_MAX_ROW:   value = max_row_i;
      CMD_MAX_COL:   value = max_col_i;
      CMD_DATA_MIN:  value = data_min_i;
      CMD_DATA_MAX:  value = data_max_i;
      CMD_COUNTDOWN: value = countdown_time_i;
      default:       value = '0;
    endcase
  end

  always_comb begin
    byte_o = '0;
    case (byte_idx_i)
      3'd0:    byte_o = cmd_i;
      3'd1:    byte_o = value[7:0];
      3'd2:    byte_o = value[15:8];
      3'd3:    byte_o = value[23:16];
      3'd4:    byte_o = value[31:24];
      default: byte_o = '0;
    endcase
  end

endmodule

// File: rtl/settings_frame_encoder.sv
// Serialises the live settings registers into a byte buffer as 5-byte frames
// (single setting or full dump of all five).
//
// state | meaning
// IDLE  | waiting for start; snapshots settings on an accepted request
// EMIT  | writes one frame byte per cycle to the buffer
// DONE  | pulses done and publishes frame_len
// ERROR | invalid command seen; terminal until rst
module settings_frame_encoder
  import settings_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cmd_id,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        frame_len,
  input  logic [31:0]       settings_max_row,
  input  logic [31:0]       settings_max_col,
  input  logic [31:0]       settings_data_min,
  input  logic [31:0]       settings_data_max,
  input  logic [31:0]       settings_countdown_time,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data
);

  if (BASE_ADDR + DUMP_BYTES > 2 ** ADDR_W) begin : g_bad_cfg
    $error("settings_frame_encoder: BASE_ADDR+25 exceeds buffer address range");
  end

  state_e            state_q, state_d;
  settings_t         snap_q, snap_d;
  logic [7:0]        fcmd_q, fcmd_d;
  logic [2:0]        byte_q, byte_d;
  logic [4:0]        off_q, off_d;
  logic              dump_q, dump_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [5:0]        frame_len_q, frame_len_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        sel_byte;

  settings_byte_select u_byte_select (
    .cmd_i            (fcmd_q),
    .byte_idx_i       (byte_q),
    .max_row_i        (snap_q.max_row),
    .max_col_i        (snap_q.max_col),
    .data_min_i       (snap_q.data_min),
    .data_max_i       (snap_q.data_max),
    .countdown_time_i (snap_q.countdown_time),
    .byte_o           (sel_byte)
  );

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    fcmd_d      = fcmd_q;
    byte_d      = byte_q;
    off_d       = off_q;
    dump_d      = dump_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    frame_len_d = frame_len_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !error_q) begin
          if (cmd_id <= CMD_COUNTDOWN) begin
            snap_d = '{max_row:        settings_max_row,
                       max_col:        settings_max_col,
                       data_min:       settings_data_min,
                       data_max:       settings_data_max,
                       countdown_time: settings_countdown_time};
            dump_d  = (cmd_id == CMD_DUMP_ALL);
            // a dump walks the frames starting from the first real code
            fcmd_d  = (cmd_id == CMD_DUMP_ALL) ? CMD_MAX_ROW : cmd_id;
            byte_d  = '0;
            off_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_EMIT;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_EMIT: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(off_q);
        wr_data_d = sel_byte;
        off_d     = off_q + 5'd1;
        if (byte_q == 3'(FRAME_BYTES - 1)) begin
          byte_d = '0;
          if (!dump_q || fcmd_q == CMD_COUNTDOWN) begin
            state_d = ST_DONE;
          end else begin
            fcmd_d = fcmd_q + 8'd1;
          end
        end else begin
          byte_d = byte_q + 3'd1;
        end
      end
      ST_DONE: begin
        done_d      = 1'b1;
        frame_len_d = dump_q ? 6'(DUMP_BYTES) : 6'(FRAME_BYTES);
        state_d     = ST_IDLE;
      end
      ST_ERROR: begin
        error_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      fcmd_q      <= '0;
      byte_q      <= '0;
      off_q       <= '0;
      dump_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      frame_len_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      fcmd_q      <= fcmd_d;
      byte_q      <= byte_d;
      off_q       <= off_d;
      dump_q      <= dump_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      frame_len_q <= frame_len_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign frame_len   = frame_len_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;

endmodule

// File: tb/tb_settings_frame_encoder.sv
// Bench for settings_frame_encoder: directed and random requests checked
// against a frame-list model of the expected buffer writes.
module tb_settings_frame_encoder;

  localparam int AW   = 5;
  localparam int BASE = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    cmd_id;
  logic [31:0]   s_row, s_col, s_min, s_max, s_cd;
  logic          busy, done, error, buf_wr_en;
  logic [5:0]    frame_len;
  logic [AW-1:0] buf_wr_addr;
  logic [7:0]    buf_wr_data;

  settings_frame_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .cmd_id                  (cmd_id),
    .busy                    (busy),
    .done                    (done),
    .error                   (error),
    .frame_len               (frame_len),
    .settings_max_row        (s_row),
    .settings_max_col        (s_col),
    .settings_data_min       (s_min),
    .settings_data_max       (s_max),
    .settings_countdown_time (s_cd),
    .buf_wr_en               (buf_wr_en),
    .buf_wr_addr             (buf_wr_addr),
    .buf_wr_data             (buf_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // observed buffer writes and done pulses
  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt = 0;
  int done_cyc = -1;
  bit busy_seen = 1'b0;

  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      wa.push_back(int'(buf_wr_addr));
      wd.push_back(int'(buf_wr_data));
      wc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  int unsigned m_val[1:5];
  int          exp_b[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Expected byte stream: frames for each requested code, cmd then value LE.
  function automatic void build_exp(input int cmd);
    exp_b.delete();
    for (int c = 1; c <= 5; c++) begin
      if (cmd == 0 || cmd == c) begin
        exp_b.push_back(c);
        for (int b = 0; b < 4; b++) exp_b.push_back(int'((m_val[c] >> (8 * b)) & 32'hFF));
      end
    end
  endfunction

  task automatic start_req(input int cmd, output int c0);
    @(negedge clk);
    wa.delete(); wd.delete(); wc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    busy_seen = 1'b0;
    m_val[1] = s_row; m_val[2] = s_col; m_val[3] = s_min;
    m_val[4] = s_max; m_val[5] = s_cd;
    build_exp(cmd);
    c0     = cyc;
    start  = 1'b1;
    cmd_id = 8'(cmd);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic finish_req(input string tag, input int c0);
    int n;
    n = exp_b.size();
    for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk($sformatf("%s_done_count", tag), done_cnt, 1);
    chk($sformatf("%s_n_writes", tag), wa.size(), n);
    for (int k = 0; k < n && k < wa.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa[k], BASE + k);
      chk($sformatf("%s_data%0d", tag, k), wd[k], exp_b[k]);
      chk($sformatf("%s_cyc%0d", tag, k), wc[k], c0 + 2 + k);
    end
    chk($sformatf("%s_done_cyc", tag), done_cyc, c0 + 2 + n);
    chk($sformatf("%s_frame_len", tag), frame_len, n);
    chk($sformatf("%s_busy_idle", tag), busy, 0);
  endtask

  initial begin
    int c0;
    int cmd;
    rst = 1'b1; start = 1'b0; cmd_id = '0;
    s_row = 32'd10; s_col = 32'd20; s_min = 32'hFFFF_FF9C; s_max = 32'd65535; s_cd = 32'd12;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_wr_data", buf_wr_data, 0);
    rst = 1'b0;

    start_req(1, c0);
    finish_req("row", c0);
    if (wd.size() >= 2) chk("row_value_byte", wd[1], 8'h0A);

    start_req(3, c0);
    finish_req("dmin", c0);
    if (wd.size() >= 5) chk("dmin_top_byte", wd[4], 8'hFF);

    start_req(0, c0);
    finish_req("dump", c0);
    if (wd.size() >= 25) begin
      chk("dump_f4_cmd", wd[15], 8'h04);
      chk("dump_f4_b1", wd[16], 8'hFF);
      chk("dump_f5_cmd", wd[20], 8'h05);
      chk("dump_f5_b1", wd[21], 8'h0C);
    end

    // settings change and a repeated start while busy
    start_req(1, c0);
    s_row = 32'd8;
    start = 1'b1; cmd_id = 8'd1;
    @(negedge clk);
    start = 1'b0;
    finish_req("snap", c0);
    if (wd.size() >= 2) chk("snap_value_byte", wd[1], 8'h0A);

    // invalid command then ignored start
    start_req(6, c0);
    chk("err_flag", error, 1);
    chk("err_busy", busy, 0);
    start_req(1, c0);
    repeat (20) @(negedge clk);
    chk("err_busy_seen", busy_seen, 0);
    chk("err_no_writes", wa.size(), 0);
    chk("err_no_done", done_cnt, 0);
    chk("err_sticky", error, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", error, 0);
    s_col = 32'd32;
    start_req(2, c0);
    finish_req("col", c0);

    // reset in the middle of a dump
    start_req(0, c0);
    while (cyc < c0 + 4) @(negedge clk);
    chk("mid_third_byte", buf_wr_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_wr_en", buf_wr_en, 0);
    chk("mid_done", done, 0);
    repeat (30) @(negedge clk);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_writes", wa.size(), 3);
    start_req(5, c0);
    finish_req("cd", c0);

    // random settings and commands
    for (int it = 0; it < 8; it++) begin
      s_row = $urandom; s_col = $urandom; s_min = $urandom;
      s_max = $urandom; s_cd = $urandom;
      cmd = int'($urandom_range(0, 5));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      start_req(cmd, c0);
      finish_req($sformatf("rnd%0d_c%0d", it, cmd), c0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
